// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch->decode and decode->execute handshake bundles
//
// dec_in_if  : fetch side. master = fetch (drives in_valid/in_instr/in_pc),
//              slave = decode stage (drives in_ready).
// dec_out_if : execute side. master = decode stage (drives the decoded entry),
//              slave = execute (drives out_ready).

interface dec_in_if #(
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;

    modport master (output in_valid, output in_instr, output in_pc, input in_ready);
    modport slave  (input in_valid, input in_instr, input in_pc, output in_ready);
endinterface

interface dec_out_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [4:0]          reg_source_0;
    logic [4:0]          reg_source_1;
    logic [4:0]          reg_dest;
    logic [XLEN-1:0]     imm;
    logic                instr_valid;
    logic                is_ecall;
    logic                is_ebreak;

    modport master (
        output out_valid, output out_pc, output opcode, output func3, output func7,
        output reg_source_0, output reg_source_1, output reg_dest, output imm,
        output instr_valid, output is_ecall, output is_ebreak,
        input  out_ready
    );
    modport slave (
        input  out_valid, input out_pc, input opcode, input func3, input func7,
        input  reg_source_0, input reg_source_1, input reg_dest, input imm,
        input  instr_valid, input is_ecall, input is_ebreak,
        output out_ready
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/RV64I decode stage with valid/ready flow control
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          drop the held entry and any same-cycle input
//   fe             dec_in_if.slave  : in_valid/in_ready/in_instr/in_pc
//   ex             dec_out_if.master: out_valid/out_ready, out_pc and decoded fields,
//                  imm (XLEN, sign-extended), instr_valid, is_ecall, is_ebreak
//   illegal_count  saturating count of accepted illegal instructions

module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter bit SYS_EN    = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    dec_in_if.slave              fe,
    dec_out_if.master            ex,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    logic [31:0]        instr;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [6:0]         f7_shift;
    logic               legal_d;
    logic               ecall_d;
    logic               ebreak_d;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_d;
    logic               accept;

    logic                 valid_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [31:0]          instr_q;
    logic [XLEN-1:0]      imm_q;
    logic                 legal_q;
    logic                 ecall_q;
    logic                 ebreak_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign instr = fe.in_instr;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    // On RV64 the shift amount borrows instr[25], so only func7[6:1] carries the
    // logical/arithmetic selector.
    assign f7_shift = (XLEN == 64) ? {f7[6:1], 1'b0} : f7;

    always_comb begin
        legal_d  = 1'b0;
        ecall_d  = 1'b0;
        ebreak_d = 1'b0;
        imm32    = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                legal_d = 1'b1;
                imm32   = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                legal_d = 1'b1;
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                legal_d = (f3 == 3'd0);
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LOAD: begin
                legal_d = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                legal_d = (f3 <= 3'd2);
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                legal_d = (f3 != 3'd2) && (f3 != 3'd3);
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_OP: begin
                legal_d = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            OPC_OPIMM: begin
                case (f3)
                    3'd1:    legal_d = (f7_shift == 7'h00);
                    3'd5:    legal_d = (f7_shift == 7'h00) || (f7_shift == 7'h20);
                    default: legal_d = 1'b1;
                endcase
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_MISC: begin
                legal_d = SYS_EN && (f3 == 3'd0);
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_SYSTEM: begin
                ecall_d  = SYS_EN && (instr == INSTR_ECALL);
                ebreak_d = SYS_EN && (instr == INSTR_EBREAK);
                legal_d  = ecall_d || ebreak_d;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            default: legal_d = 1'b0;
        endcase
        // Illegal encodings never expose a stray immediate to execute.
        if (!legal_d) begin
            imm32 = '0;
        end
    end

    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    assign imm_d = XLEN'(imm32);

    assign fe.in_ready = !valid_q || ex.out_ready;
    assign accept      = fe.in_valid && fe.in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            imm_q    <= '0;
            legal_q  <= 1'b0;
            ecall_q  <= 1'b0;
            ebreak_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            pc_q     <= fe.in_pc;
            instr_q  <= instr;
            imm_q    <= imm_d;
            legal_q  <= legal_d;
            ecall_q  <= ecall_d;
            ebreak_q <= ebreak_d;
        end else if (ex.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !legal_d && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign ex.out_valid    = valid_q;
    assign ex.out_pc       = pc_q;
    assign ex.opcode       = instr_q[6:0];
    assign ex.func3        = instr_q[14:12];
    assign ex.func7        = instr_q[31:25];
    assign ex.reg_source_0 = instr_q[19:15];
    assign ex.reg_source_1 = instr_q[24:20];
    assign ex.reg_dest     = instr_q[11:7];
    assign ex.imm          = imm_q;
    assign ex.instr_valid  = legal_q;
    assign ex.is_ecall     = ecall_q;
    assign ex.is_ebreak    = ebreak_q;
    assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_a = 1'b0;
    logic        flush_b = 1'b0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // a: RV64, SYS_EN=1, 16-bit counter.  b: RV32, SYS_EN=0, 2-bit counter.
    dec_in_if  #(.PC_WIDTH(32))              a_in ();
    dec_out_if #(.XLEN(64), .PC_WIDTH(32))   a_out ();
    dec_in_if  #(.PC_WIDTH(32))              b_in ();
    dec_out_if #(.XLEN(32), .PC_WIDTH(32))   b_out ();

    decode_stage #(.XLEN(64), .PC_WIDTH(32), .SYS_EN(1'b1), .CNT_WIDTH(16)) u_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush_a),
        .fe            (a_in.slave),
        .ex            (a_out.master),
        .illegal_count (cnt_a)
    );

    decode_stage #(.XLEN(32), .PC_WIDTH(32), .SYS_EN(1'b0), .CNT_WIDTH(2)) u_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush_b),
        .fe            (b_in.slave),
        .ex            (b_out.master),
        .illegal_count (cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        a_in.in_valid = 1'b1;
        a_in.in_instr = ins;
        a_in.in_pc    = pc;
        @(posedge clk);
        #1;
        a_in.in_valid = 1'b0;
    endtask

    task automatic step_b(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        b_in.in_valid = 1'b1;
        b_in.in_instr = ins;
        b_in.in_pc    = pc;
        @(posedge clk);
        #1;
        b_in.in_valid = 1'b0;
    endtask

    initial begin
        a_in.in_valid   = 1'b0;
        a_in.in_instr   = '0;
        a_in.in_pc      = '0;
        a_out.out_ready = 1'b1;
        b_in.in_valid   = 1'b0;
        b_in.in_instr   = '0;
        b_in.in_pc      = '0;
        b_out.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out.out_valid, 0);
        chk("rst_imm", a_out.imm, 0);
        chk("rst_opcode", a_out.opcode, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI x1, x0, 5
        step_a(32'h0050_0093, 32'h0000_0100);
        chk("addi_valid", a_out.out_valid, 1);
        chk("addi_imm", a_out.imm, 64'd5);
        chk("addi_rd", a_out.reg_dest, 1);
        chk("addi_legal", a_out.instr_valid, 1);
        chk("addi_pc", a_out.out_pc, 32'h100);

        // LW x1, -4(x2)
        step_a(32'hFFC1_2083, 32'h0000_0104);
        chk("lw_imm", a_out.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("lw_f3", a_out.func3, 2);
        chk("lw_rs1", a_out.reg_source_0, 2);
        chk("lw_legal", a_out.instr_valid, 1);

        // BEQ x0, x0, -4
        step_a(32'hFE00_0EE3, 32'h0000_0108);
        chk("beq_imm", a_out.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_legal", a_out.instr_valid, 1);

        // LUI x1, 0x80000 : U immediate sign-extended to 64 bits
        step_a(32'h8000_00B7, 32'h0000_010C);
        chk("lui64_imm", a_out.imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_opc", a_out.opcode, 7'h37);

        // Backpressure: LUI entry held for 3 cycles while ADDI x2,x0,10 waits
        @(negedge clk);
        a_out.out_ready = 1'b0;
        a_in.in_valid   = 1'b1;
        a_in.in_instr   = 32'h00A0_0113;
        a_in.in_pc      = 32'h0000_0110;
        #1;
        chk("bp_in_ready", a_in.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", a_out.out_valid, 1);
            chk("bp_hold_opc", a_out.opcode, 7'h37);
            chk("bp_hold_pc", a_out.out_pc, 32'h10C);
        end
        @(negedge clk);
        a_out.out_ready = 1'b1;
        #1;
        chk("bp_ready_again", a_in.in_ready, 1);
        @(posedge clk);
        #1;
        a_in.in_valid = 1'b0;
        chk("bp_next_opc", a_out.opcode, 7'h13);
        chk("bp_next_imm", a_out.imm, 64'd10);
        chk("bp_next_rd", a_out.reg_dest, 2);

        // SRAI x1,x1,63 : legal on RV64 (shamt bit 5 in instr[25])
        step_a(32'h43F0_D093, 32'h0000_0114);
        chk("srai64_legal", a_out.instr_valid, 1);
        chk("srai64_imm", a_out.imm, 64'h43F);

        // SUB legal, OP with func7=0x20 func3=1 illegal
        step_a(32'h4000_0033, 32'h0000_0118);
        chk("sub_legal", a_out.instr_valid, 1);
        chk("sub_imm", a_out.imm, 0);
        step_a(32'h4000_1033, 32'h0000_011C);
        chk("op_bad_legal", a_out.instr_valid, 0);
        chk("op_bad_cnt", cnt_a, 1);

        // Unknown opcode and JALR func3=2
        step_a(32'h0000_007F, 32'h0000_0120);
        chk("ill7f_legal", a_out.instr_valid, 0);
        chk("ill7f_imm", a_out.imm, 0);
        step_a(32'h0000_2067, 32'h0000_0124);
        chk("jalr_bad_legal", a_out.instr_valid, 0);
        chk("jalr_bad_cnt", cnt_a, 3);

        // Flush with a held entry and an illegal input in the same cycle
        @(negedge clk);
        flush_a       = 1'b1;
        a_in.in_valid = 1'b1;
        a_in.in_instr = 32'h0000_007F;
        @(posedge clk);
        #1;
        flush_a       = 1'b0;
        a_in.in_valid = 1'b0;
        chk("flush_valid", a_out.out_valid, 0);
        chk("flush_cnt", cnt_a, 3);

        // SYSTEM / MISC-MEM with SYS_EN=1
        step_a(32'h0010_0073, 32'h0000_0200);
        chk("ebreak_flag", a_out.is_ebreak, 1);
        chk("ebreak_legal", a_out.instr_valid, 1);
        chk("ebreak_ecall", a_out.is_ecall, 0);
        step_a(32'h0000_0073, 32'h0000_0204);
        chk("ecall_flag", a_out.is_ecall, 1);
        step_a(32'h0020_0073, 32'h0000_0208);
        chk("sys_bad_legal", a_out.instr_valid, 0);
        chk("sys_bad_ebreak", a_out.is_ebreak, 0);
        chk("sys_bad_cnt", cnt_a, 4);
        step_a(32'h0000_000F, 32'h0000_020C);
        chk("fence_legal_a", a_out.instr_valid, 1);

        // Idle cycle with out_ready=1 drains the entry
        @(posedge clk);
        #1;
        chk("drain_valid", a_out.out_valid, 0);

        // RV32, SYS_EN=0, 2-bit counter
        step_b(32'h8000_00B7, 32'h0000_0300);
        chk("lui32_imm", b_out.imm, 32'h8000_0000);
        chk("lui32_legal", b_out.instr_valid, 1);
        step_b(32'h0000_000F, 32'h0000_0304);
        chk("fence_b_legal", b_out.instr_valid, 0);
        chk("fence_b_cnt", cnt_b, 1);
        step_b(32'h0000_0073, 32'h0000_0308);
        chk("ecall_b_flag", b_out.is_ecall, 0);
        chk("ecall_b_legal", b_out.instr_valid, 0);
        step_b(32'h43F0_D093, 32'h0000_030C);
        chk("srai32_legal", b_out.instr_valid, 0);
        chk("sat_cnt_3", cnt_b, 3);
        step_b(32'h0000_2067, 32'h0000_0310);
        step_b(32'h0000_007F, 32'h0000_0314);
        chk("sat_cnt_hold", cnt_b, 3);

        // Asynchronous reset mid-transfer
        step_a(32'h0050_0093, 32'h0000_0400);
        chk("pre_rst_valid", a_out.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", a_out.out_valid, 0);
        chk("arst_imm", a_out.imm, 0);
        chk("arst_cnt_a", cnt_a, 0);
        chk("arst_cnt_b", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
